frame_sequencer: RTL and testbench

//  Per-frame controller for the sprite pipeline: on vsync it starts a framebuffer clear, opens the draw window
//  to the sprite distributor/renderers, detects drain (host committed, queue empty, all renderers idle),

---
 rtl/frame_sequencer_pkg.sv | 20 ++
 rtl/frame_sequencer_if.sv | 34 +++
 rtl/frame_sequencer_drain_detector.sv | 37 +++
 rtl/frame_sequencer.sv | 127 ++++++++++++
 tb/tb_frame_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_sequencer_pkg.sv
// Purpose : shared types and default sizing for the per-frame sprite sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package frame_sequencer_pkg;

  localparam int DEF_NUM_RENDERERS = 2;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CLEAR_TIMEOUT = 1024;
  localparam int DEF_CNT_W         = 16;

  // Encoding is visible on the debug state port; keep the order stable.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    DRAW      = 3'd2,
    SWAP_WAIT = 3'd3,
    SWAP      = 3'd4
  } frame_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Purpose : bundles the display-timing, host, framebuffer and sprite-driver signals of the sequencer.
// Latency : n/a (wiring only).
// Backpressure: swap is a req/ack level-pulse pair; everything else is pulse or level, no stalls.
// Ports   : master = frame_sequencer side, slave = the surrounding blocks (timing, host, fb, sprite_driver).
interface frame_sequencer_if
  import frame_sequencer_pkg::*;
#(
  parameter int NUM_RENDERERS = DEF_NUM_RENDERERS,
  parameter int CNT_W         = DEF_CNT_W
);
  logic                     vsync_start;
  logic                     host_commit;
  logic                     fb_clear_start;
  logic                     fb_resetting;
  logic                     draw_enable;
  logic                     sprite_queue_is_empty;
  logic [NUM_RENDERERS-1:0] render_busy;
  logic                     fb_swap_req;
  logic                     fb_swap_ack;
  logic                     frame_done;
  logic [CNT_W-1:0]         overrun_count;
  logic                     clear_timeout;
  frame_state_t             state;

  modport master (
    input  vsync_start, host_commit, fb_resetting, sprite_queue_is_empty, render_busy, fb_swap_ack,
    output fb_clear_start, draw_enable, fb_swap_req, frame_done, overrun_count, clear_timeout, state
  );

  modport slave (
    output vsync_start, host_commit, fb_resetting, sprite_queue_is_empty, render_busy, fb_swap_ack,
    input  fb_clear_start, draw_enable, fb_swap_req, frame_done, overrun_count, clear_timeout, state
  );
endinterface

// File: rtl/frame_sequencer_drain_detector.sv
// Purpose : counts consecutive idle DRAW cycles and flags the frame as drained.
// Latency : drained is combinational, high in the SETTLE_CYCLES-th consecutive idle cycle.
// Backpressure: none; any non-idle cycle (or leaving DRAW) restarts the count.
// Ports   : enable (in DRAW), commit (host commit latched), queue_empty, render_busy -> drained.
module frame_sequencer_drain_detector
  import frame_sequencer_pkg::*;
#(
  parameter int NUM_RENDERERS = DEF_NUM_RENDERERS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     commit,
  input  logic                     queue_empty,
  input  logic [NUM_RENDERERS-1:0] render_busy,
  output logic                     drained
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic          idle;
  logic [SW-1:0] settle_q;

  assign idle    = enable && commit && queue_empty && (render_busy == '0);
  // Fires on the last idle cycle so the FSM leaves DRAW on that same edge.
  assign drained = idle && (settle_q == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      settle_q <= '0;
    end else if (idle) begin
      settle_q <= settle_q + 1'b1;
    end else begin
      settle_q <= '0;
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// Purpose : per-frame controller: clear on vsync, open draw window, detect drain, request swap on next vsync.
// Latency : vsync_start -> fb_clear_start 1 cycle; fb_swap_ack -> frame_done/fb_clear_start 1 cycle.
// Backpressure: fb_swap_req held until fb_swap_ack; vsyncs arriving while still clearing/drawing are counted, not queued.
// Ports   : clock, reset (sync, active-low), bus (frame_sequencer_if.master: timing, host, fb and sprite signals).
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int NUM_RENDERERS = DEF_NUM_RENDERERS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CLEAR_TIMEOUT = DEF_CLEAR_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  frame_sequencer_if.master bus
);
  localparam int TW = $clog2(CLEAR_TIMEOUT + 1);

  frame_state_t   state_q, state_d;
  logic           clr_start_q, clr_start_d;
  logic           done_q, done_d;
  logic           ovr_inc, tmo_set, tmo_q;
  logic           seen_q, commit_q, commit_nxt_q;
  logic           drained, swap_ack, in_clear;
  logic [TW-1:0]  tmo_cnt_q;
  logic [CNT_W-1:0] ovr_q;

  assign swap_ack = (state_q == SWAP) && bus.fb_swap_ack;
  // True while we remain in CLEAR across this edge; seen flag and timeout restart on every entry.
  assign in_clear = (state_q == CLEAR) && (state_d == CLEAR);

  frame_sequencer_drain_detector #(
    .NUM_RENDERERS (NUM_RENDERERS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_drain (
    .clock       (clock),
    .reset       (reset),
    .enable      (state_q == DRAW),
    .commit      (commit_q),
    .queue_empty (bus.sprite_queue_is_empty),
    .render_busy (bus.render_busy),
    .drained     (drained)
  );

  always_comb begin
    state_d     = state_q;
    clr_start_d = 1'b0;
    done_d      = 1'b0;
    ovr_inc     = 1'b0;
    tmo_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vsync_start) begin
          state_d     = CLEAR;
          clr_start_d = 1'b1;
        end
      end
      CLEAR: begin
        ovr_inc = bus.vsync_start;
        if (seen_q && !bus.fb_resetting) begin
          state_d = DRAW;
        end else if (!seen_q && !bus.fb_resetting && (tmo_cnt_q == TW'(CLEAR_TIMEOUT - 1))) begin
          tmo_set = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // A vsync on the drain cycle is the swap vsync, not a miss.
        if (drained) begin
          state_d = bus.vsync_start ? SWAP : SWAP_WAIT;
        end else begin
          ovr_inc = bus.vsync_start;
        end
      end
      SWAP_WAIT: begin
        if (bus.vsync_start) state_d = SWAP;
      end
      SWAP: begin
        if (bus.fb_swap_ack) begin
          state_d     = CLEAR;
          clr_start_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      clr_start_q  <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= '0;
      tmo_q        <= 1'b0;
      seen_q       <= 1'b0;
      tmo_cnt_q    <= '0;
      commit_q     <= 1'b0;
      commit_nxt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_start_q <= clr_start_d;
      done_q      <= done_d;
      if (ovr_inc && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
      if (tmo_set) tmo_q <= 1'b1;
      seen_q    <= in_clear ? (seen_q | bus.fb_resetting) : 1'b0;
      tmo_cnt_q <= in_clear ? (tmo_cnt_q + 1'b1) : '0;
      // Commits after drain belong to the next frame: park them until the swap retires this one.
      if (swap_ack) begin
        commit_q     <= commit_nxt_q | bus.host_commit;
        commit_nxt_q <= 1'b0;
      end else if ((state_q == SWAP_WAIT) || (state_q == SWAP)) begin
        commit_nxt_q <= commit_nxt_q | bus.host_commit;
      end else begin
        commit_q <= commit_q | bus.host_commit;
      end
    end
  end

  assign bus.fb_clear_start = clr_start_q;
  assign bus.draw_enable    = (state_q == DRAW);
  assign bus.fb_swap_req    = (state_q == SWAP);
  assign bus.frame_done     = done_q;
  assign bus.overrun_count  = ovr_q;
  assign bus.clear_timeout  = tmo_q;
  assign bus.state          = state_q;
endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int NR = 2, SC = 4, CT = 1024, CW = 16;
  localparam int OVR_MAX = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_DRAW = 2, P_SWAIT = 3, P_SWAP = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0, errors = 0, cyc = 0;

  frame_sequencer_if #(.NUM_RENDERERS(NR), .CNT_W(CW)) bus();

  frame_sequencer #(
    .NUM_RENDERERS (NR),
    .SETTLE_CYCLES (SC),
    .CLEAR_TIMEOUT (CT),
    .CNT_W         (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: phase of the frame, how long we've been clearing, how long the
  // frame has been quiet, and which frame the host's commit applies to.
  int m_ph, m_ovr, m_run, m_age;
  bit m_cs, m_done, m_tmo, m_cmt, m_cmt_nx, m_saw;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  nph;
    bit  quiet, v, fr;
    if (!reset) begin
      m_ph = P_IDLE; m_ovr = 0; m_run = 0; m_age = 0;
      m_cs = 0; m_done = 0; m_tmo = 0; m_cmt = 0; m_cmt_nx = 0; m_saw = 0;
      return;
    end
    v     = bus.vsync_start;
    fr    = bus.fb_resetting;
    quiet = m_cmt && bus.sprite_queue_is_empty && (bus.render_busy == '0);
    nph   = m_ph;
    m_cs  = 0;
    m_done = 0;
    if (m_ph == P_IDLE && v) begin
      nph = P_CLEAR; m_cs = 1;
    end else if (m_ph == P_CLEAR) begin
      if (v && m_ovr < OVR_MAX) m_ovr++;
      if (m_saw && !fr) nph = P_DRAW;
      else if (!m_saw && !fr && m_age == CT - 1) begin nph = P_DRAW; m_tmo = 1; end
    end else if (m_ph == P_DRAW) begin
      if (quiet && m_run + 1 == SC) nph = v ? P_SWAP : P_SWAIT;
      else if (v && m_ovr < OVR_MAX) m_ovr++;
    end else if (m_ph == P_SWAIT && v) begin
      nph = P_SWAP;
    end else if (m_ph == P_SWAP && bus.fb_swap_ack) begin
      nph = P_CLEAR; m_cs = 1; m_done = 1;
    end
    if (m_ph == P_SWAP && bus.fb_swap_ack) begin
      m_cmt = m_cmt_nx | bus.host_commit; m_cmt_nx = 0;
    end else if (m_ph >= P_SWAIT) m_cmt_nx |= bus.host_commit;
    else m_cmt |= bus.host_commit;
    m_run = (m_ph == P_DRAW && nph == P_DRAW && quiet) ? m_run + 1 : 0;
    m_saw = (m_ph == P_CLEAR && nph == P_CLEAR) ? (m_saw | fr) : 0;
    m_age = (m_ph == P_CLEAR && nph == P_CLEAR) ? m_age + 1 : 0;
    m_ph  = nph;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    check("mdl_state",     32'(bus.state),          32'(m_ph));
    check("mdl_clr_start", 32'(bus.fb_clear_start), 32'(m_cs));
    check("mdl_draw_en",   32'(bus.draw_enable),    32'(m_ph == P_DRAW));
    check("mdl_swap_req",  32'(bus.fb_swap_req),    32'(m_ph == P_SWAP));
    check("mdl_done",      32'(bus.frame_done),     32'(m_done));
    check("mdl_overrun",   32'(bus.overrun_count),  32'(m_ovr));
    check("mdl_timeout",   32'(bus.clear_timeout),  32'(m_tmo));
  endtask

  task automatic step(bit v, bit c, bit fr, bit ack);
    bus.vsync_start = v; bus.host_commit = c; bus.fb_resetting = fr; bus.fb_swap_ack = ack;
    tick();
  endtask

  typedef struct {
    bit v, c, fr, ack;
    int st;
    bit cs, de, req, done;
  } vec_t;
  vec_t tbl[$];

  initial begin
    bus.vsync_start = 0; bus.host_commit = 0; bus.fb_resetting = 0; bus.fb_swap_ack = 0;
    bus.sprite_queue_is_empty = 1; bus.render_busy = '0;

    // Reset state
    reset = 0;
    tick(); tick();
    check("rst_state", 32'(bus.state), 32'(P_IDLE));
    check("rst_outs", {27'd0, bus.fb_clear_start, bus.draw_enable, bus.fb_swap_req, bus.frame_done, bus.clear_timeout}, 32'd0);
    check("rst_overrun", 32'(bus.overrun_count), 32'd0);
    reset = 1;

    // Nominal frame: vsync, 10-cycle clear, commit, 4 quiet cycles, swap on next vsync
    tbl.push_back(vec_t'{1, 0, 0, 0, P_CLEAR, 1, 0, 0, 0});
    for (int i = 0; i < 10; i++) tbl.push_back(vec_t'{0, 0, 1, 0, P_CLEAR, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, P_DRAW, 0, 1, 0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back(vec_t'{0, 0, 0, 0, P_DRAW, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, P_SWAIT, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, P_SWAIT, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0, P_SWAP, 0, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, P_SWAP, 0, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, P_CLEAR, 1, 0, 0, 1});
    tbl.push_back(vec_t'{0, 0, 0, 0, P_CLEAR, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, tbl[i].fr, tbl[i].ack);
      check($sformatf("nom_state[%0d]", i), 32'(bus.state),          32'(tbl[i].st));
      check($sformatf("nom_cs[%0d]", i),    32'(bus.fb_clear_start), 32'(tbl[i].cs));
      check($sformatf("nom_de[%0d]", i),    32'(bus.draw_enable),    32'(tbl[i].de));
      check($sformatf("nom_req[%0d]", i),   32'(bus.fb_swap_req),    32'(tbl[i].req));
      check($sformatf("nom_done[%0d]", i),  32'(bus.frame_done),     32'(tbl[i].done));
    end

    // Idle glitch: one busy cycle after 3 quiet ones restarts the settle count
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("glitch_draw", 32'(bus.state), 32'(P_DRAW));
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    bus.render_busy = 2'b01;
    step(0, 0, 0, 0);
    bus.render_busy = 2'b00;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("glitch_hold", 32'(bus.state), 32'(P_DRAW));
    step(0, 0, 0, 0);
    check("glitch_drain", 32'(bus.state), 32'(P_SWAIT));

    // vsync during SWAP is ignored; then overrun counting in DRAW and saturation
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("swap_vsync_ign", 32'(bus.overrun_count), 32'd0);
    check("swap_vsync_st",  32'(bus.state), 32'(P_SWAP));
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("ovr_three", 32'(bus.overrun_count), 32'd3);
    check("ovr_state", 32'(bus.state), 32'(P_DRAW));
    for (int i = 0; i < OVR_MAX - 4; i++) step(1, 0, 0, 0);
    check("ovr_fffe", 32'(bus.overrun_count), 32'hFFFE);
    step(1, 0, 0, 0);
    check("ovr_ffff", 32'(bus.overrun_count), 32'hFFFF);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check("ovr_sat", 32'(bus.overrun_count), 32'hFFFF);
    check("ovr_sat_state", 32'(bus.state), 32'(P_DRAW));

    // Drain coincident with vsync, then reset while requesting a swap
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("coin_sat_state", 32'(bus.state), 32'(P_SWAP));
    step(0, 0, 0, 0);
    check("pre_rst_req", 32'(bus.fb_swap_req), 32'd1);
    reset = 0;
    step(0, 0, 0, 0);
    check("mid_rst_req",   32'(bus.fb_swap_req), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'(P_IDLE));
    check("mid_rst_ovr",   32'(bus.overrun_count), 32'd0);
    reset = 1;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("coin_state", 32'(bus.state), 32'(P_SWAP));
    check("coin_ovr",   32'(bus.overrun_count), 32'd0);

    // Clear timeout: fb_resetting never rises
    step(0, 0, 0, 1);
    check("to_cs", 32'(bus.fb_clear_start), 32'd1);
    for (int i = 0; i < CT - 1; i++) step(0, 0, 0, 0);
    check("to_still_clear", 32'(bus.state), 32'(P_CLEAR));
    check("to_not_yet",     32'(bus.clear_timeout), 32'd0);
    step(0, 0, 0, 0);
    check("to_state", 32'(bus.state), 32'(P_DRAW));
    check("to_flag",  32'(bus.clear_timeout), 32'd1);

    // Randomized traffic against the model, with occasional resets
    reset = 0;
    step(0, 0, 0, 0);
    reset = 1;
    for (int i = 0; i < 4000; i++) begin
      bus.vsync_start = ($urandom_range(0, 29) == 0);
      bus.host_commit = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) bus.fb_resetting = ~bus.fb_resetting;
      bus.sprite_queue_is_empty = ($urandom_range(0, 4) != 0);
      bus.render_busy = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.fb_swap_ack = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
